// File: rtl/ysyx_22041752_msu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22041752_msu
// Purpose  : Memory-access pipeline stage between execute and write-back.
//            Issues one load/store per memory instruction on a split
//            address/data handshake port, aligns and sign-extends load data,
//            drives the MEM->WB valid/allowin handshake and publishes a
//            forwarding/stall bus to decode.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset (async, active-high)
//   es_to_ms_valid / es_to_ms_bus : instruction from execute
//       {mem_re, mem_we, mem_size[1:0], mem_unsigned, rf_we, rd,
//        alu_result, store_data, pc}
//   ms_allowin                    : stage can take a new instruction
//   ws_allowin                    : write-back accepts
//   ms_to_ws_valid / ms_to_ws_bus : {rf_we, rd, result, pc}
//   ms_forward_bus                : {fwd_valid, fwd_block, result, rd}
//   data_*                        : data-memory request/response port
//   ms_misalign                   : misaligned access flag (optional)
// Build option
//   YSYX_22041752_MISALIGN_CHECK_EN : detect misaligned H/W/D accesses,
//       suppress their request and flag them on ms_misalign.
// ============================================================================
module ysyx_22041752_msu #(
    parameter int PC_WD      = 64,
    parameter int RF_DATA_WD = 64,
    parameter int RF_ADDR_WD = 5
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       es_to_ms_valid,
    input  logic [6+RF_ADDR_WD+2*RF_DATA_WD+PC_WD-1:0] es_to_ms_bus,
    output logic                                       ms_allowin,
    input  logic                                       ws_allowin,
    output logic                                       ms_to_ws_valid,
    output logic [1+RF_ADDR_WD+RF_DATA_WD+PC_WD-1:0]   ms_to_ws_bus,
    output logic [2+RF_DATA_WD+RF_ADDR_WD-1:0]         ms_forward_bus,
    output logic                                       data_req,
    output logic                                       data_wr,
    output logic [1:0]                                 data_size,
    output logic [RF_DATA_WD-1:0]                      data_addr,
    output logic [7:0]                                 data_wstrb,
    output logic [63:0]                                data_wdata,
    input  logic                                       data_addr_ok,
    input  logic                                       data_data_ok,
    input  logic [63:0]                                data_rdata
`ifdef YSYX_22041752_MISALIGN_CHECK_EN
    ,
    output logic                                       ms_misalign
`endif
);

    localparam int c_ES_BUS_WD = 6 + RF_ADDR_WD + 2 * RF_DATA_WD + PC_WD;
    localparam int c_ST_WD     = 2;

    typedef enum logic [c_ST_WD-1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    logic                   r_ms_valid;
    logic [c_ES_BUS_WD-1:0] r_es_bus;
    logic [63:0]            r_rdata;
    logic                   r_issued;
    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   w_mem_re;
    logic                   w_mem_we;
    logic [1:0]             w_mem_size;
    logic                   w_mem_unsigned;
    logic                   w_rf_we;
    logic [RF_ADDR_WD-1:0]  w_rd;
    logic [RF_DATA_WD-1:0]  w_alu_result;
    logic [RF_DATA_WD-1:0]  w_store_data;
    logic [PC_WD-1:0]       w_pc;

    logic                   w_is_mem;
    logic                   w_misalign;
    logic                   w_ready_go;
    logic                   w_bus_load;
    logic                   w_issue;
    logic                   w_capture;
    logic                   w_rf_we_out;
    logic [63:0]            w_shifted;
    logic [63:0]            w_load;
    logic [RF_DATA_WD-1:0]  w_result;
    logic [7:0]             w_strb_base;

    assign {w_mem_re, w_mem_we, w_mem_size, w_mem_unsigned, w_rf_we,
            w_rd, w_alu_result, w_store_data, w_pc} = r_es_bus;

    assign w_is_mem = w_mem_re | w_mem_we;

`ifdef YSYX_22041752_MISALIGN_CHECK_EN
    always_comb begin
        w_misalign = 1'b0;
        case (w_mem_size)
            2'd1:    w_misalign = w_alu_result[0];
            2'd2:    w_misalign = |w_alu_result[1:0];
            2'd3:    w_misalign = |w_alu_result[2:0];
            default: w_misalign = 1'b0;
        endcase
    end
    assign ms_misalign = r_ms_valid & w_is_mem & w_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    // ---------------- valid/allowin handshake ----------------
    assign w_ready_go     = !w_is_mem || (r_state == S_DONE);
    assign ms_allowin     = !r_ms_valid || (w_ready_go && ws_allowin);
    assign ms_to_ws_valid = r_ms_valid && w_ready_go;
    assign w_bus_load     = es_to_ms_valid && ms_allowin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ms_valid <= 1'b0;
            r_es_bus   <= '0;
        end else begin
            if (ms_allowin) begin
                r_ms_valid <= es_to_ms_valid;
            end
            if (w_bus_load) begin
                r_es_bus <= es_to_ms_bus;
            end
        end
    end

    // ---------------- memory-access FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_ms_valid && w_is_mem && !r_issued) begin
                    w_issue     = 1'b1;
                    // A misaligned access never reaches the memory port.
                    w_state_nxt = w_misalign ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (ws_allowin) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Issued flag: cleared whenever a new instruction enters, so each
    // instruction can issue at most once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issued <= 1'b0;
        end else if (w_bus_load) begin
            r_issued <= 1'b0;
        end else if (w_issue) begin
            r_issued <= 1'b1;
        end
    end

    // Hold register keeps load data through write-back back-pressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_capture) begin
            r_rdata <= data_rdata;
        end
    end

    // ---------------- memory request port ----------------
    // All request fields come straight from the bus register, which cannot
    // change while the instruction is still waiting in REQ.
    assign data_req  = (r_state == S_REQ);
    assign data_wr   = w_mem_we;
    assign data_size = w_mem_size;
    assign data_addr = w_alu_result;

    always_comb begin
        w_strb_base = 8'h01;
        data_wdata  = {8{w_store_data[7:0]}};
        case (w_mem_size)
            2'd0: begin
                w_strb_base = 8'h01;
                data_wdata  = {8{w_store_data[7:0]}};
            end
            2'd1: begin
                w_strb_base = 8'h03;
                data_wdata  = {4{w_store_data[15:0]}};
            end
            2'd2: begin
                w_strb_base = 8'h0F;
                data_wdata  = {2{w_store_data[31:0]}};
            end
            default: begin
                w_strb_base = 8'hFF;
                data_wdata  = w_store_data[63:0];
            end
        endcase
    end
    assign data_wstrb = w_strb_base << w_alu_result[2:0];

    // ---------------- load alignment ----------------
    assign w_shifted = r_rdata >> {w_alu_result[2:0], 3'b000};

    always_comb begin
        w_load = w_shifted;
        case (w_mem_size)
            2'd0:    w_load = w_mem_unsigned ? {56'd0, w_shifted[7:0]}
                                             : {{56{w_shifted[7]}}, w_shifted[7:0]};
            2'd1:    w_load = w_mem_unsigned ? {48'd0, w_shifted[15:0]}
                                             : {{48{w_shifted[15]}}, w_shifted[15:0]};
            2'd2:    w_load = w_mem_unsigned ? {32'd0, w_shifted[31:0]}
                                             : {{32{w_shifted[31]}}, w_shifted[31:0]};
            default: w_load = w_shifted;
        endcase
    end

    assign w_result    = w_mem_re ? w_load : w_alu_result;
    // Stores and misaligned accesses never write the register file.
    assign w_rf_we_out = w_rf_we & !w_mem_we & !(w_is_mem & w_misalign);

    assign ms_to_ws_bus   = {w_rf_we_out, w_rd, w_result, w_pc};
    assign ms_forward_bus = {r_ms_valid & w_rf_we_out,
                             r_ms_valid & w_mem_re & !w_ready_go,
                             w_result, w_rd};

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041752_msu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22041752_msu
// Purpose  : Directed self-checking bench for the memory-access stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_22041752_msu;

    localparam int c_ES_WD  = 203;
    localparam int c_WS_WD  = 134;
    localparam int c_FWD_WD = 71;

    logic                clk = 1'b0;
    logic                reset;
    logic                es_to_ms_valid;
    logic [c_ES_WD-1:0]  es_to_ms_bus;
    logic                ms_allowin;
    logic                ws_allowin;
    logic                ms_to_ws_valid;
    logic [c_WS_WD-1:0]  ms_to_ws_bus;
    logic [c_FWD_WD-1:0] ms_forward_bus;
    logic                data_req;
    logic                data_wr;
    logic [1:0]          data_size;
    logic [63:0]         data_addr;
    logic [7:0]          data_wstrb;
    logic [63:0]         data_wdata;
    logic                data_addr_ok;
    logic                data_data_ok;
    logic [63:0]         data_rdata;
`ifdef YSYX_22041752_MISALIGN_CHECK_EN
    logic                ms_misalign;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int n_req    = 0;
    int base;

    ysyx_22041752_msu dut (
        .clk            (clk),
        .reset          (reset),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .ms_allowin     (ms_allowin),
        .ws_allowin     (ws_allowin),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ms_to_ws_bus   (ms_to_ws_bus),
        .ms_forward_bus (ms_forward_bus),
        .data_req       (data_req),
        .data_wr        (data_wr),
        .data_size      (data_size),
        .data_addr      (data_addr),
        .data_wstrb     (data_wstrb),
        .data_wdata     (data_wdata),
        .data_addr_ok   (data_addr_ok),
        .data_data_ok   (data_data_ok),
        .data_rdata     (data_rdata)
`ifdef YSYX_22041752_MISALIGN_CHECK_EN
        ,
        .ms_misalign    (ms_misalign)
`endif
    );

    always #5 clk = ~clk;

    // Accepted request handshakes.
    always @(posedge clk) begin
        if (!reset && data_req && data_addr_ok) n_req++;
    end

    function automatic logic [c_ES_WD-1:0] mk(
        input logic re, input logic we, input logic [1:0] size,
        input logic uns, input logic rfwe, input logic [4:0] rd,
        input logic [63:0] alu, input logic [63:0] sd, input logic [63:0] pc);
        return {re, we, size, uns, rfwe, rd, alu, sd, pc};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [c_ES_WD-1:0] bus);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = bus;
        tick();
        es_to_ms_valid = 1'b0;
    endtask

    // Load with addr_ok in the first REQ cycle and data_ok the next cycle.
    task automatic load_fast(input string tag, input logic [c_ES_WD-1:0] bus,
                             input logic [63:0] rdata, input logic [63:0] exp);
        issue(bus);
        chk({tag, "_block_idle"}, ms_forward_bus[69], 1'b1);
        tick();
        chk({tag, "_req"}, data_req, 1'b1);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = rdata;
        tick();
        data_data_ok = 1'b0;
        data_rdata   = 64'hDEAD_BEEF_DEAD_BEEF;
        chk({tag, "_valid"}, ms_to_ws_valid, 1'b1);
        chk({tag, "_result"}, ms_to_ws_bus[127:64], exp);
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus   = '0;
        ws_allowin     = 1'b1;
        data_addr_ok   = 1'b0;
        data_data_ok   = 1'b0;
        data_rdata     = '0;
        tick();
        tick();

        // Reset state
        chk("rst_valid",   ms_to_ws_valid, 1'b0);
        chk("rst_req",     data_req, 1'b0);
        chk("rst_allowin", ms_allowin, 1'b1);
        chk("rst_fwd",     ms_forward_bus, '0);
        chk("rst_bus",     ms_to_ws_bus, '0);
        reset = 1'b0;
        tick();

        // ALU op
        issue(mk(0, 0, 2'd0, 0, 1, 5'd5, 64'h1234, 64'h0, 64'h8000_0000));
        chk("alu_valid", ms_to_ws_valid, 1'b1);
        chk("alu_bus",   ms_to_ws_bus, {1'b1, 5'd5, 64'h1234, 64'h8000_0000});
        chk("alu_req",   data_req, 1'b0);
        chk("alu_fwd",   ms_forward_bus, {1'b1, 1'b0, 64'h1234, 5'd5});
        tick();
        chk("alu_drain", ms_to_ws_valid, 1'b0);

        // LB / LBU
        load_fast("lb", mk(1, 0, 2'd0, 0, 1, 5'd7, 64'h1003, 64'h0, 64'h8000_0004),
                  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        load_fast("lbu", mk(1, 0, 2'd0, 1, 1, 5'd7, 64'h1003, 64'h0, 64'h8000_0008),
                  64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);

        // SH with addr_ok and data_ok in the same cycle
        issue(mk(0, 1, 2'd1, 0, 1, 5'd9, 64'h2006, 64'hABCD, 64'h8000_000C));
        tick();
        chk("sh_req",   data_req, 1'b1);
        chk("sh_wr",    data_wr, 1'b1);
        chk("sh_wstrb", data_wstrb, 8'hC0);
        chk("sh_wdata", data_wdata, 64'hABCD_ABCD_ABCD_ABCD);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        chk("sh_valid", ms_to_ws_valid, 1'b1);
        chk("sh_rfwe",  ms_to_ws_bus[133], 1'b0);
        tick();

        // LD: addr_ok delayed 3 cycles, ws_allowin low 4 cycles after data_ok
        base       = n_req;
        ws_allowin = 1'b0;
        issue(mk(1, 0, 2'd3, 0, 1, 5'd10, 64'h4000, 64'h0, 64'h8000_0010));
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("ld_req_held", {data_req, data_wr, data_size, data_wstrb, data_addr},
                {1'b1, 1'b0, 2'd3, 8'hFF, 64'h4000});
            chk("ld_block_req", ms_forward_bus[69], 1'b1);
            tick();
        end
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        chk("ld_block_wait", ms_forward_bus[69], 1'b1);
        chk("ld_req_low",    data_req, 1'b0);
        data_data_ok = 1'b1;
        data_rdata   = 64'h1122_3344_5566_7788;
        tick();
        data_data_ok = 1'b0;
        data_rdata   = '0;
        for (int i = 0; i < 4; i++) begin
            chk("ld_stall", {ms_to_ws_valid, ms_allowin, ms_forward_bus[69], data_req},
                {1'b1, 1'b0, 1'b0, 1'b0});
            chk("ld_hold", ms_to_ws_bus[127:64], 64'h1122_3344_5566_7788);
            tick();
        end
        ws_allowin = 1'b1;
        #1;
        chk("ld_allowin", ms_allowin, 1'b1);
        chk("ld_one_req", n_req - base, 1);
        tick();

        // Reset while in WAIT
        issue(mk(1, 0, 2'd2, 0, 1, 5'd11, 64'h5000, 64'h0, 64'h8000_0014));
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_req",     data_req, 1'b0);
        chk("arst_valid",   ms_to_ws_valid, 1'b0);
        chk("arst_allowin", ms_allowin, 1'b1);
        chk("arst_fwd",     ms_forward_bus, '0);
        tick();
        reset = 1'b0;
        tick();
        chk("arst_idle", {data_req, ms_to_ws_valid}, 2'b00);
        issue(mk(0, 0, 2'd0, 0, 1, 5'd3, 64'h77, 64'h0, 64'h8000_0018));
        chk("arst_alu_bus", {ms_to_ws_valid, ms_to_ws_bus},
            {1'b1, 1'b1, 5'd3, 64'h77, 64'h8000_0018});
        tick();

        // LW at 0x3002
        base = n_req;
        issue(mk(1, 0, 2'd2, 0, 1, 5'd12, 64'h3002, 64'h0, 64'h8000_001C));
        tick();
`ifdef YSYX_22041752_MISALIGN_CHECK_EN
        chk("mis_valid", ms_to_ws_valid, 1'b1);
        chk("mis_flag",  ms_misalign, 1'b1);
        chk("mis_rfwe",  ms_to_ws_bus[133], 1'b0);
        chk("mis_noreq", data_req, 1'b0);
        tick();
        chk("mis_reqcnt", n_req - base, 0);
`else
        chk("lw_unchecked_req",  data_req, 1'b1);
        chk("lw_unchecked_addr", data_addr, 64'h3002);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 64'hCAFE_F00D_8765_4321;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        // Bytes 2..5 of the word 0xCAFEF00D_87654321 -> 0xF00D8765, sign-extended.
        chk("lw_unchecked_res", ms_to_ws_bus[127:64], 64'hFFFF_FFFF_F00D_8765);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
